// File: rtl/transport_rcv_mc.sv
// Network-side packet receiver: buffers bytes in a FIFO, decodes each full packet's header and
// delivers the payload as WORD_W-bit words over valid/ready; bad packets are dropped and counted.
module transport_rcv_mc #(
  parameter int unsigned PKT_BYTES  = 16,
  parameter int unsigned WORD_W     = 16,
  parameter int unsigned CHANNELS   = 2,
  parameter int unsigned FIFO_DEPTH = 2048,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic [7:0]                    in_data,
  output logic                          in_ready,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WORD_W-1:0]             out_data,
  output logic [1:0]                    out_type,
  output logic [5:0]                    out_chan,
  output logic                          out_last,
  output logic                          err_pulse,
  output logic [CNT_W-1:0]              err_count,
  output logic [CNT_W-1:0]              ovf_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned WORD_BYTES  = WORD_W / 8;
  localparam int unsigned AUDIO_WORDS = (PKT_BYTES - 1) / WORD_BYTES;
  localparam int unsigned AW          = $clog2(FIFO_DEPTH);
  localparam int unsigned RW          = $clog2(PKT_BYTES + 1);
  localparam int unsigned BW          = $clog2(WORD_BYTES + 1);

  typedef logic [AW:0] cnt_t;

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StAssemble,
    StPresent,
    StDiscard
  } state_e;

  // Byte FIFO
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  cnt_t             count_q;
  logic [CNT_W-1:0] ovf_q;
  logic             push, pop;
  logic [7:0]       head;

  assign in_ready   = (count_q != cnt_t'(FIFO_DEPTH));
  assign push       = in_valid && in_ready;
  assign head       = mem_q[rd_ptr_q];
  assign fifo_count = count_q;
  assign ovf_count  = ovf_q;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop)      count_q <= count_q + cnt_t'(1);
      else if (pop && !push) count_q <= count_q - cnt_t'(1);
      if (in_valid && !in_ready && (ovf_q != '1)) ovf_q <= ovf_q + CNT_W'(1);
    end
  end

  // Packet FSM
  state_e            state_q, state_d;
  logic [RW-1:0]     rem_q, rem_d;
  logic [RW-1:0]     words_q, words_d;
  logic [BW-1:0]     bcnt_q, bcnt_d;
  logic [WORD_W-1:0] shift_q, shift_d, shift_nxt;
  logic [1:0]        type_q, type_d;
  logic [5:0]        chan_q, chan_d;
  logic              out_valid_q, out_valid_d;
  logic [WORD_W-1:0] out_data_q, out_data_d;
  logic [1:0]        out_type_q, out_type_d;
  logic [5:0]        out_chan_q, out_chan_d;
  logic              out_last_q, out_last_d;
  logic              err_pulse_q, err_pulse_d;
  logic [CNT_W-1:0]  err_count_q, err_count_d;
  logic              hdr_ok;

  // First byte received ends up in the MSBs.
  assign shift_nxt = (shift_q << 8) | WORD_W'(head);
  assign hdr_ok    = ((head[7:6] == 2'b01) || (head[7:6] == 2'b10)) &&
                     ({1'b0, head[5:0]} < 7'(CHANNELS));

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    words_d     = words_q;
    bcnt_d      = bcnt_q;
    shift_d     = shift_q;
    type_d      = type_q;
    chan_d      = chan_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_type_d  = out_type_q;
    out_chan_d  = out_chan_q;
    out_last_d  = out_last_q;
    err_pulse_d = 1'b0;
    err_count_d = err_count_q;
    pop         = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (count_q >= cnt_t'(PKT_BYTES)) state_d = StHdr;
      end
      StHdr: begin
        pop    = 1'b1;
        type_d = head[7:6];
        chan_d = head[5:0];
        rem_d  = RW'(PKT_BYTES - 1);
        bcnt_d = '0;
        if (hdr_ok) begin
          words_d = (head[7:6] == 2'b01) ? RW'(1) : RW'(AUDIO_WORDS);
          state_d = StAssemble;
        end else begin
          err_pulse_d = 1'b1;
          if (err_count_q != '1) err_count_d = err_count_q + CNT_W'(1);
          state_d = StDiscard;
        end
      end
      StAssemble: begin
        pop     = 1'b1;
        shift_d = shift_nxt;
        rem_d   = rem_q - RW'(1);
        if (bcnt_q == BW'(WORD_BYTES - 1)) begin
          bcnt_d      = '0;
          out_valid_d = 1'b1;
          out_data_d  = shift_nxt;
          out_type_d  = type_q;
          out_chan_d  = chan_q;
          out_last_d  = (words_q == RW'(1));
          state_d     = StPresent;
        end else begin
          bcnt_d = bcnt_q + BW'(1);
        end
      end
      StPresent: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          words_d     = words_q - RW'(1);
          if (words_q > RW'(1))   state_d = StAssemble;
          else if (rem_q != '0)   state_d = StDiscard;
          else                    state_d = StIdle;
        end
      end
      StDiscard: begin
        // Always entered with rem >= 1, so the last pop also leaves the state.
        pop   = 1'b1;
        rem_d = rem_q - RW'(1);
        if (rem_q == RW'(1)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      rem_q       <= '0;
      words_q     <= '0;
      bcnt_q      <= '0;
      shift_q     <= '0;
      type_q      <= '0;
      chan_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_type_q  <= '0;
      out_chan_q  <= '0;
      out_last_q  <= 1'b0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      words_q     <= words_d;
      bcnt_q      <= bcnt_d;
      shift_q     <= shift_d;
      type_q      <= type_d;
      chan_q      <= chan_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_type_q  <= out_type_d;
      out_chan_q  <= out_chan_d;
      out_last_q  <= out_last_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_type  = out_type_q;
  assign out_chan  = out_chan_q;
  assign out_last  = out_last_q;
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;

endmodule

// File: doc/transport_rcv_mc.md
Name: transport_rcv_mc

Overview:
Parametrised, multi-channel successor to the network-side packet receiver. It buffers raw bytes from the network in an internal byte FIFO. Once a whole packet is buffered it decodes the header byte and reassembles the payload into WORD_W-bit words. It delivers those words to the session layer over a valid/ready handshake, tagged with type and channel, and it drops and counts malformed packets and overflowed bytes.

Parameters:
PKT_BYTES, 16, bytes per packet including the 1 header byte; must be at least 1+WORD_BYTES.
WORD_W, 16, output word width; must be a multiple of 8. WORD_BYTES = WORD_W/8.
CHANNELS, 2, number of valid channel ids, 1..64.
FIFO_DEPTH, 2048, byte FIFO depth; must be a power of 2 and at least PKT_BYTES.
CNT_W, 16, width of the error and overflow counters.

Ports:
clk  in  1  system clock; all logic is on its rising edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  a network byte is present on in_data
in_data  in  8  network byte
in_ready  out  1  FIFO not full
out_valid  out  1  out_data, out_type, out_chan and out_last are valid
out_ready  in  1  session accepts the word
out_data  out  WORD_W  reassembled word; first byte received sits in the MSBs
out_type  out  2  01 = control, 10 = audio
out_chan  out  6  channel id from the header
out_last  out  1  final word of the packet
err_pulse  out  1  one-cycle pulse when a packet is dropped as invalid
err_count  out  CNT_W  saturating count of invalid packets
ovf_count  out  CNT_W  saturating count of bytes dropped because the FIFO was full
fifo_count  out  clog2(FIFO_DEPTH)+1  bytes currently buffered

Behaviour:
- Reset (reset=0, asynchronous) clears all of the following:
  - FIFO pointers and fifo_count, which becomes 0.
  - The FSM, which returns to IDLE.
  - All outputs: out_valid=0, out_data=0, out_type=0, out_chan=0, out_last=0, err_pulse=0, err_count=0, ovf_count=0.
  - in_ready reads 1 after reset.
  - Reset mid-packet discards the partial packet and all buffered bytes.
- FIFO:
  - A push occurs when in_valid && in_ready.
  - in_valid while full drops the byte and increments ovf_count, saturating at all-ones.
  - The FIFO head is combinationally visible; a pop takes effect on the clock edge.
  - A simultaneous push and pop leaves fifo_count unchanged; pointers wrap modulo FIFO_DEPTH.
- Header decode:
  - hdr[7:6] is the type: 01 = control, 10 = audio; 00 and 11 are invalid.
  - hdr[5:0] is the channel; channel >= CHANNELS is invalid.
- FSM states:
  - IDLE: go to HDR when fifo_count >= PKT_BYTES. Reading never starts on a partial packet.
  - HDR: pop the header and latch type and channel; set rem = PKT_BYTES-1.
    - Valid header: set words_left = 1 for control or AUDIO_WORDS = (PKT_BYTES-1)/WORD_BYTES for audio, then go to ASSEMBLE.
    - Invalid header: pulse err_pulse for 1 cycle, increment err_count (saturating), go to DISCARD.
  - ASSEMBLE: pop one byte per cycle, shifting it into the word MSB-first, and decrement rem. After WORD_BYTES pops, load the output registers, set out_valid=1 and go to PRESENT. out_last=1 when words_left==1.
  - PRESENT: hold out_data, out_type, out_chan and out_last stable while out_valid && !out_ready. On the handshake, clear out_valid and decrement words_left, then:
    - words_left > 0 after decrement: go to ASSEMBLE.
    - otherwise, rem > 0: go to DISCARD.
    - otherwise: go to IDLE.
  - DISCARD: pop one byte per cycle until rem==0, then go to IDLE. No output activity during DISCARD.
- Trailing bytes are always discarded and never emitted:
  - Control packets: PKT_BYTES-1-WORD_BYTES bytes.
  - Audio packets: (PKT_BYTES-1) mod WORD_BYTES bytes.
- Latency: the first out_valid is asserted 2+WORD_BYTES cycles after the cycle in which fifo_count first reaches PKT_BYTES (IDLE, HDR, then WORD_BYTES ASSEMBLE cycles, with out_valid visible on the following cycle).
- Back-to-back packets:
  - After IDLE is re-entered, the next packet starts at least 1 cycle later.
  - Throughput with out_ready held high is 1 word per WORD_BYTES+1 cycles.
- out_ready has no effect outside PRESENT.
- err_pulse and out_valid are never asserted in the same cycle.

Test Plan:
1. Audio packet: push 8'h81 followed by bytes 8'h01..8'h0F, out_ready=1.
   -> 7 words 16'h0102, 16'h0304, ..., 16'h0D0E, each with out_type=10 and out_chan=1; out_last only on 16'h0D0E; byte 8'h0F is discarded; fifo_count returns to 0.
2. Control packet: push 8'h40, 8'hA5, 8'h5A, then 13 filler bytes.
   -> exactly one word 16'hA55A with out_type=01, out_chan=0, out_last=1; no further out_valid.
3. Invalid packets: push a packet with header 8'hC0, then one with 8'h83 (CHANNELS=2), then a valid audio packet.
   -> two err_pulses, err_count=2, no out_valid for the first two packets; the third packet is delivered intact.
4. Backpressure: run scenario 1, holding out_ready=0 for 5 cycles on the third word.
   -> out_data holds 16'h0506 with out_valid high; no pops occur; the sequence completes correctly once out_ready=1.
5. Overflow (FIFO_DEPTH=32, out_ready=0): push header 8'h81 followed by 39 bytes on consecutive cycles.
   -> the FSM stalls in PRESENT after 3 pops; in_ready drops once 32 bytes are stored; ovf_count=5; fifo_count=32.
6. Reset mid-packet: assert reset during the fourth audio word, then release it and send scenario 2.
   -> all outputs are 0 immediately on reset, fifo_count=0; the control word 16'hA55A is delivered correctly afterwards.
